piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in/serial-out transmitter. It is the sending end of the serial bit stream that the team's D-flip-flop capture chains receive.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Drives the word out one bit per clock on q, qualified by q_valid.
- Supports gap-free back-to-back words. Sits between parallel datapath logic and a single-wire serial link.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1: bit WIDTH-1 is sent first; 0: bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word to transmit.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  block can accept a word this cycle (combinational).
- q  output  1  serial data out (registered).
- q_valid  output  1  q carries a frame bit (registered).
- done  output  1  high while the last bit of a frame is on q (registered).
- busy  output  1  state is SHIFT (registered).

Behaviour:
- Reset, asynchronous: state=IDLE, shift register=0, bit counter=0, q=0, q_valid=0, done=0, busy=0. Takes effect immediately, independent of clk.
- Reset mid-frame: the word in progress is discarded. No partial bits follow reset release.
- FSM states are IDLE and SHIFT.
- load_ready = (state==IDLE) | (state==SHIFT & cnt==FRAME_LEN-1).
  - FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature.
- Accept: a rising edge with load_valid & load_ready.
  - Captures data_in and sets cnt=0, state=SHIFT.
  - First bit appears on q with q_valid=1 immediately after that same edge. Latency is 0 cycles from the accept edge, 1 cycle from load_valid sampling.
- SHIFT: on each edge cnt increments and the next bit is presented. Bit order follows MSB_FIRST.
- At cnt==FRAME_LEN-1:
  - done=1 for that one cycle.
  - Next edge with accept: reload the new word, cnt=0, stay in SHIFT. No idle gap and no q_valid drop.
  - Next edge without accept: state=IDLE, q_valid=0, q=0, done=0, busy=0.
- load_valid while load_ready=0 is ignored. The source must hold the word; data_in is not sampled.
- data_in changes after the accept edge do not affect the frame in flight.
- The counter width is the minimum needed to hold FRAME_LEN-1. The counter never wraps past FRAME_LEN-1.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits, captured at accept) is appended after the data bits.
  - FRAME_LEN = WIDTH+1.
  - done and load_ready align to the parity-bit cycle.
- Undefined: FRAME_LEN = WIDTH. No parity logic is synthesised.

Decomposition:
- Shared package piso_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - a clog2 helper function for the counter width;
  - the FRAME_LEN derivation constant, selected by the macro.
- Single module. No sub-module is warranted; the counter and shift register are a few lines each.

Test Plan:
- Reset then idle, WIDTH=8: hold rst=1 for 2 cycles, release, load_valid=0 for 5 cycles -> q=0, q_valid=0, done=0, busy=0, load_ready=1 throughout.
- Single word, MSB_FIRST=1: load 8'hA5 -> q sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles, q_valid=1 for exactly 8 cycles, done high only on the 8th, then idle.
- LSB-first: MSB_FIRST=0, load 8'h01 -> q = 1 then 0 ×7.
- Back-to-back: load_valid held with 8'hF0 then 8'h0F -> 16 contiguous q_valid cycles, bits 1111000000001111, load_ready=1 only on idle and on each done cycle.
- Async reset mid-frame: load 8'hFF, assert rst between edges on bit 4 -> q, q_valid, busy fall to 0 without a clock edge; after release, no residual bits until a new load.
- Parity (PISO_TX_PARITY_EN): load 8'h07 -> 8 data bits then parity bit 1, 9 q_valid cycles, done on the 9th.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and frame-length constants for the piso_tx serial transmitter.
// Defining PISO_TX_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Number of bits needed to count from 0 up to value-1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

`ifdef PISO_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word load, one bit per clock on q.
// Optional even-parity trailer bit enabled by defining PISO_TX_PARITY_EN.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             done,
  output logic             busy
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [FRAME_LEN-1:0] sreg;
  logic [FRAME_LEN-1:0] frame;
  logic                 accept;

  // The parity bit is placed so that it always leaves after the last data bit.
`ifdef PISO_TX_PARITY_EN
  assign frame = MSB_FIRST ? {data_in, ^data_in} : {^data_in, data_in};
`else
  assign frame = data_in;
`endif

  function automatic logic first_bit(input logic [FRAME_LEN-1:0] v);
    return MSB_FIRST ? v[FRAME_LEN-1] : v[0];
  endfunction

  function automatic logic [FRAME_LEN-1:0] drop_first(input logic [FRAME_LEN-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_ready = 1'b0;
    case (state)
      IDLE:    load_ready = 1'b1;
      SHIFT:   load_ready = (cnt == LAST);
      default: load_ready = 1'b0;
    endcase
    accept = load_valid & load_ready;
    if (accept) begin
      state_next = SHIFT;
      cnt_next   = '0;
    end else if (state == SHIFT) begin
      if (cnt == LAST) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: state uses non-blocking assignments; reset is asynchronous so it
  // clears the frame in flight without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The first bit goes straight to q on the accept edge; sreg keeps the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else if (accept) begin
      sreg    <= drop_first(frame);
      q       <= first_bit(frame);
      q_valid <= 1'b1;
      done    <= 1'b0;
      busy    <= 1'b1;
    end else if (state == SHIFT && cnt != LAST) begin
      sreg    <= drop_first(sreg);
      q       <= first_bit(sreg);
      q_valid <= 1'b1;
      done    <= (cnt_next == LAST);
      busy    <= 1'b1;
    end else begin
      sreg    <= '0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (MSB-first and LSB-first instances).
// Expectations follow PISO_TX_PARITY_EN when it is defined.
module tb_piso_tx;

  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = 9;
  // Send-order vectors: bit FL-1 leaves first.
  localparam logic [FL-1:0] EXP_A5  = 9'b1010_0101_0;
  localparam logic [FL-1:0] EXP_F0  = 9'b1111_0000_0;
  localparam logic [FL-1:0] EXP_0F  = 9'b0000_1111_0;
  localparam logic [FL-1:0] EXP_LSB = 9'b1000_0000_1;
  localparam logic [FL-1:0] EXP_07  = 9'b0000_0111_1;
`else
  localparam int FL = 8;
  localparam logic [FL-1:0] EXP_A5  = 8'b1010_0101;
  localparam logic [FL-1:0] EXP_F0  = 8'b1111_0000;
  localparam logic [FL-1:0] EXP_0F  = 8'b0000_1111;
  localparam logic [FL-1:0] EXP_LSB = 8'b1000_0000;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, q, q_valid, done, busy;
  logic [W-1:0] data_in_l = '0;
  logic         load_valid_l = 1'b0;
  logic         load_ready_l, q_l, q_valid_l, done_l, busy_l;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .q(q), .q_valid(q_valid), .done(done), .busy(busy)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .data_in(data_in_l), .load_valid(load_valid_l),
    .load_ready(load_ready_l), .q(q_l), .q_valid(q_valid_l), .done(done_l), .busy(busy_l)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed/expected vectors are {q, q_valid, done, busy, load_ready}.
  task automatic test_reset();
    rst = 1'b1;
    step();
    total_cnt++;
    if ({q, q_valid, done, busy, load_ready} !== 5'b00001)
      $display("FAIL reset_hold: got %b want 00001", {q, q_valid, done, busy, load_ready});
    else pass_cnt++;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if ({q, q_valid, done, busy, load_ready} !== 5'b00001)
        $display("FAIL reset_idle[%0d]: got %b want 00001", i, {q, q_valid, done, busy, load_ready});
      else pass_cnt++;
    end
  endtask

  task automatic test_single_msb();
    data_in = 8'hA5;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      total_cnt++;
      if ({q, q_valid, done, busy, load_ready} !== {EXP_A5[FL-1-i], 1'b1, i == FL-1, 1'b1, i == FL-1})
        $display("FAIL single_msb[%0d]: got %b want %b", i, {q, q_valid, done, busy, load_ready},
                 {EXP_A5[FL-1-i], 1'b1, i == FL-1, 1'b1, i == FL-1});
      else pass_cnt++;
      // A load attempt while not ready must be ignored.
      if (i == 2) begin
        load_valid = 1'b1;
        data_in = 8'h00;
      end
      if (i == 3) load_valid = 1'b0;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if ({q, q_valid, done, busy, load_ready} !== 5'b00001)
        $display("FAIL single_msb_idle[%0d]: got %b want 00001", i, {q, q_valid, done, busy, load_ready});
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_lsb_first();
    data_in_l = 8'h01;
    load_valid_l = 1'b1;
    step();
    load_valid_l = 1'b0;
    for (int i = 0; i < FL; i++) begin
      total_cnt++;
      if ({q_l, q_valid_l, done_l, busy_l, load_ready_l} !== {EXP_LSB[FL-1-i], 1'b1, i == FL-1, 1'b1, i == FL-1})
        $display("FAIL lsb_first[%0d]: got %b want %b", i, {q_l, q_valid_l, done_l, busy_l, load_ready_l},
                 {EXP_LSB[FL-1-i], 1'b1, i == FL-1, 1'b1, i == FL-1});
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({q_l, q_valid_l, done_l, busy_l, load_ready_l} !== 5'b00001)
      $display("FAIL lsb_first_idle: got %b want 00001", {q_l, q_valid_l, done_l, busy_l, load_ready_l});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic exp_bit;
    data_in = 8'hF0;
    load_valid = 1'b1;
    step();
    // Changing data_in after accept must not disturb the frame in flight.
    data_in = 8'h0F;
    for (int i = 0; i < 2 * FL; i++) begin
      exp_bit = (i < FL) ? EXP_F0[FL-1-i] : EXP_0F[2*FL-1-i];
      total_cnt++;
      if ({q, q_valid, done, busy, load_ready} !== {exp_bit, 1'b1, (i % FL) == FL-1, 1'b1, (i % FL) == FL-1})
        $display("FAIL back_to_back[%0d]: got %b want %b", i, {q, q_valid, done, busy, load_ready},
                 {exp_bit, 1'b1, (i % FL) == FL-1, 1'b1, (i % FL) == FL-1});
      else pass_cnt++;
      if (i == FL) load_valid = 1'b0;
      step();
    end
    total_cnt++;
    if ({q, q_valid, done, busy, load_ready} !== 5'b00001)
      $display("FAIL back_to_back_idle: got %b want 00001", {q, q_valid, done, busy, load_ready});
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    data_in = 8'hFF;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total_cnt++;
    if ({q, q_valid, busy} !== 3'b111)
      $display("FAIL async_pre: got %b want 111", {q, q_valid, busy});
    else pass_cnt++;
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({q, q_valid, done, busy, load_ready} !== 5'b00001)
      $display("FAIL async_reset_no_edge: got %b want 00001", {q, q_valid, done, busy, load_ready});
    else pass_cnt++;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if ({q, q_valid, done, busy, load_ready} !== 5'b00001)
        $display("FAIL async_after[%0d]: got %b want 00001", i, {q, q_valid, done, busy, load_ready});
      else pass_cnt++;
    end
    data_in = 8'hA5;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    total_cnt++;
    if ({q, q_valid, done, busy} !== 4'b1101)
      $display("FAIL async_reload: got %b want 1101", {q, q_valid, done, busy});
    else pass_cnt++;
    for (int i = 0; i < FL + 1; i++) step();
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity();
    data_in = 8'h07;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      total_cnt++;
      if ({q, q_valid, done, busy, load_ready} !== {EXP_07[FL-1-i], 1'b1, i == FL-1, 1'b1, i == FL-1})
        $display("FAIL parity[%0d]: got %b want %b", i, {q, q_valid, done, busy, load_ready},
                 {EXP_07[FL-1-i], 1'b1, i == FL-1, 1'b1, i == FL-1});
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({q, q_valid, done, busy, load_ready} !== 5'b00001)
      $display("FAIL parity_idle: got %b want 00001", {q, q_valid, done, busy, load_ready});
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_msb();
    test_lsb_first();
    test_back_to_back();
    test_async_reset();
`ifdef PISO_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
